jk_latch_monitor: RTL
=====================

# jk_latch_monitor

Clocked consumer of a gate-level JK latch's asynchronous `Q`/`Qn` pair: synchronizes both rails, filters glitches, and emits a clean state with single-cycle edge pulses. Detects illegal rail combinations (`Q == Qn`) and reports a sticky fault. Sits directly downstream of the JK latch, bridging its unclocked outputs into the synchronous fabric.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth per rail, minimum 2.
- `STABLE_CYCLES`, 4: consecutive identical synchronized samples required to accept a code, minimum 1.
- `CNT_W`, 16: toggle counter width.

Ports:
- `clk`  in  1: single clock; everything is on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `Q`  in  1: latch true output, asynchronous to `clk`.
- `Qn`  in  1: latch complement output, asynchronous to `clk`.
- `clr_fault`  in  1: leaves FAULT, level-sampled.
- `q_clean`  out  1: filtered latch state.
- `valid`  out  1: 1 in LOW or HIGH only.
- `rise`  out  1: one-cycle pulse on an accepted LOW→HIGH change.
- `fall`  out  1: one-cycle pulse on an accepted HIGH→LOW change.
- `fault`  out  1: 1 while in FAULT.
- `toggle_cnt`  out  CNT_W: count of accepted rise and fall events.

## Operation
- Each rail passes through its own `SYNC_STAGES`-flop chain, reset to 0.
- Synchronized pair {q_s, qn_s} maps to codes: 10 = HIGH, 01 = LOW, 00/11 = INVALID.
- Stability counter:
  - Clears to 1 when the code differs from the previous cycle.
  - Otherwise increments, saturating at `STABLE_CYCLES`.
  - A code is accepted on the cycle the counter reaches `STABLE_CYCLES`, and on every later cycle it stays there.
- State machine (reset → UNKNOWN):
  - UNKNOWN: accepted LOW → LOW; accepted HIGH → HIGH; accepted INVALID → FAULT. No rise/fall pulse; `q_clean` follows the accepted value.
  - LOW: accepted HIGH → HIGH with `rise`=1 and `toggle_cnt`+1. Accepted INVALID → FAULT.
  - HIGH: accepted LOW → LOW with `fall`=1 and `toggle_cnt`+1. Accepted INVALID → FAULT.
  - FAULT: `fault`=1, `valid`=0, `q_clean` holds its last value. `clr_fault`=1 → UNKNOWN on the next edge and clears the stability counter to 0.
- `clr_fault` has no effect outside FAULT.
- If INVALID persists after a clear, FAULT re-enters after `STABLE_CYCLES` cycles.
- `toggle_cnt` wraps modulo 2^CNT_W. It is not cleared by leaving FAULT; only reset clears it.
- Reset values: `q_clean`=0, `valid`=0, `rise`=0, `fall`=0, `fault`=0, `toggle_cnt`=0, sync flops 0, stability counter 0, state UNKNOWN.
- Reset asserted mid-operation overrides everything on that edge, including a pending pulse or `clr_fault`.

## Timing
- All outputs are registered. `rise`/`fall` assert in the same cycle `q_clean` changes and last exactly one cycle.
- Latency: a rail change first sampled at edge 1 updates `q_clean`/state at edge `SYNC_STAGES + STABLE_CYCLES`. Default is 6 cycles.
- A code change shorter than `STABLE_CYCLES` synchronized cycles is discarded: no state change, no pulse.
- Back-to-back accepted transitions are at least `STABLE_CYCLES` cycles apart, so pulses never merge.
- FAULT → UNKNOWN takes 1 cycle after `clr_fault` is sampled. The next valid state follows after `STABLE_CYCLES` further cycles of a stable legal code.

## Configuration
- `JK_MON_TOGGLE_CNT_EN` defined: toggle counter built as described.
- `JK_MON_TOGGLE_CNT_EN` undefined: counter logic omitted and `toggle_cnt` tied to 0. The port list is unchanged; all other behaviour is identical.

## Test plan
- Reset, then hold Q=0, Qn=1 → `valid`=1 and `q_clean`=0 at cycle 6 (defaults), no `fall` pulse, `toggle_cnt`=0.
- From LOW, drive Q=1, Qn=0 → `rise` high for exactly 1 cycle, 6 cycles after the change. `q_clean`=1 and `toggle_cnt`=1.
- From HIGH, apply a 2-cycle glitch to Q=0, Qn=1, then return to HIGH → no `fall`, `q_clean` stays 1, `toggle_cnt` unchanged.
- From LOW, drive Q=1, Qn=1 for 10 cycles → `fault`=1 and `valid`=0, `q_clean` holds 0. Pulse `clr_fault` with the rails still 11 → UNKNOWN for 1 cycle, then re-fault after 4 cycles. Pulse `clr_fault` with the rails at 10 → `valid`=1, `q_clean`=1, no `rise`.
- With `CNT_W`=2 → 5 accepted toggles give `toggle_cnt`=1 (wrap). With `JK_MON_TOGGLE_CNT_EN` undefined, the same stimulus holds `toggle_cnt`=0.
- Assert `rst_n`=0 on the cycle a `rise` would fire → `rise`=0, all outputs at reset values on the next edge.

Source files
------------

// File: rtl/jk_latch_monitor.sv
// jk_latch_monitor: brings the asynchronous Q/Qn rails of a gate-level JK latch
// into the clk domain. Each rail is synchronized, the rail pair is debounced
// by a stability counter, and a small FSM turns accepted codes into a clean
// state, one-cycle rise/fall pulses and a sticky fault on illegal codes.
// Optional feature macro: JK_MON_TOGGLE_CNT_EN builds the toggle counter;
// without it toggle_cnt is tied to zero.
module jk_latch_monitor #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Q,
    input  logic             Qn,
    input  logic             clr_fault,
    output logic             q_clean,
    output logic             valid,
    output logic             rise,
    output logic             fall,
    output logic             fault,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
    localparam logic [1:0] CODE_HIGH = 2'b10;
    localparam logic [1:0] CODE_LOW  = 2'b01;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_LOW     = 2'd1,
        ST_HIGH    = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] q_sync;
    logic [SYNC_STAGES-1:0] qn_sync;
    logic [1:0]             code;
    logic [1:0]             prev_code;
    logic [STAB_W-1:0]      stab_cnt;
    logic [STAB_W-1:0]      stab_next;
    logic                   accept;
    logic                   clear_stab;
    state_t                 state;
    state_t                 state_next;
    logic                   q_next;
    logic                   rise_next;
    logic                   fall_next;

    // Per-rail synchronizer chains; the newest sample enters at bit 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_sync  <= '0;
            qn_sync <= '0;
        end else begin
            q_sync  <= {q_sync[SYNC_STAGES-2:0], Q};
            qn_sync <= {qn_sync[SYNC_STAGES-2:0], Qn};
        end
    end

    assign code = {q_sync[SYNC_STAGES-1], qn_sync[SYNC_STAGES-1]};

    // Stability count for this cycle's code; a code is accepted on the cycle
    // the count lands on (or stays at) STABLE_CYCLES.
    always_comb begin
        stab_next = stab_cnt;
        if (code != prev_code) begin
            stab_next = STAB_W'(1);
        end else if (stab_cnt != STAB_MAX) begin
            stab_next = stab_cnt + STAB_W'(1);
        end
    end

    assign accept     = (stab_next == STAB_MAX);
    assign clear_stab = (state == ST_FAULT) && clr_fault;

    // Previous-code and stability-count registers; a fault clear restarts the count from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_code <= 2'b00;
            stab_cnt  <= '0;
        end else begin
            prev_code <= code;
            stab_cnt  <= clear_stab ? '0 : stab_next;
        end
    end

    // Next-state and next-output decode for the latch-state FSM.
    always_comb begin
        state_next = state;
        q_next     = q_clean;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            ST_UNKNOWN: begin
                if (accept) begin
                    if (code == CODE_LOW) begin
                        state_next = ST_LOW;
                        q_next     = 1'b0;
                    end else if (code == CODE_HIGH) begin
                        state_next = ST_HIGH;
                        q_next     = 1'b1;
                    end else begin
                        state_next = ST_FAULT;
                    end
                end
            end
            ST_LOW: begin
                if (accept) begin
                    if (code == CODE_HIGH) begin
                        state_next = ST_HIGH;
                        q_next     = 1'b1;
                        rise_next  = 1'b1;
                    end else if (code != CODE_LOW) begin
                        state_next = ST_FAULT;
                    end
                end
            end
            ST_HIGH: begin
                if (accept) begin
                    if (code == CODE_LOW) begin
                        state_next = ST_LOW;
                        q_next     = 1'b0;
                        fall_next  = 1'b1;
                    end else if (code != CODE_HIGH) begin
                        state_next = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                if (clr_fault) begin
                    state_next = ST_UNKNOWN;
                end
            end
            default: state_next = ST_UNKNOWN;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_UNKNOWN;
            q_clean <= 1'b0;
            valid   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= state_next;
            q_clean <= q_next;
            valid   <= (state_next == ST_LOW) || (state_next == ST_HIGH);
            rise    <= rise_next;
            fall    <= fall_next;
            fault   <= (state_next == ST_FAULT);
        end
    end

`ifdef JK_MON_TOGGLE_CNT_EN
    // Count accepted edges; wraps naturally and only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            toggle_cnt <= '0;
        end else if (rise_next || fall_next) begin
            toggle_cnt <= toggle_cnt + CNT_W'(1);
        end
    end
`else
    assign toggle_cnt = '0;
`endif

endmodule
